// File: rtl/control_sequencer_if.sv
// Datapath control bus between control_sequencer and ALU_System.
// master = sequencer (drives controls, reads IROut/ALU_Flag); slave = datapath.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  ALU_Flag;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel;
  logic [3:0]  RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;

  modport master (
    input  IROut, ALU_Flag,
    output RF_OutASel, RF_OutBSel, RF_FunSel,
    output RF_RSel, RF_TSel, ALU_FunSel,
    output ARF_OutCSel, ARF_OutDSel,
    output ARF_FunSel, ARF_RegSel,
    output IR_LH, IR_Enable, IR_Funsel,
    output Mem_WR, Mem_CS,
    output MuxASel, MuxBSel, MuxCSel
  );

  modport slave (
    output IROut, ALU_Flag,
    input  RF_OutASel, RF_OutBSel, RF_FunSel,
    input  RF_RSel, RF_TSel, ALU_FunSel,
    input  ARF_OutCSel, ARF_OutDSel,
    input  ARF_FunSel, ARF_RegSel,
    input  IR_LH, IR_Enable, IR_Funsel,
    input  Mem_WR, Mem_CS,
    input  MuxASel, MuxBSel, MuxCSel
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for ALU_System.
// Ports: Clock, Reset (sync, high), Run, bus (master), Halted, Illegal, Step.
module control_sequencer (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Run,
  control_sequencer_if.master        bus,
  output logic                       Halted,
  output logic                       Illegal,
  output logic [2:0]                 Step
);

  localparam logic [1:0] PC_SEL = 2'b00;
  localparam logic [1:0] AR_SEL = 2'b01;

  localparam logic [3:0] OP_ALU = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_BRA = 4'h4;
  localparam logic [3:0] OP_BZ  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'h6;

  // Encoding doubles as the Step value.
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_HALT = 3'd7
  } state_t;

  state_t state, state_n;

  logic [3:0] op;
  logic [1:0] dst, src;
  logic [3:0] dst_oh;
  logic       unused_bits;

  assign op     = bus.IROut[15:12];
  assign dst    = bus.IROut[11:10];
  assign src    = bus.IROut[9:8];
  assign dst_oh = 4'b1000 >> dst;
  // imm[3:0] and C/N/O flags are datapath-only.
  assign unused_bits = ^{bus.IROut[3:0], bus.ALU_Flag[2:0]};

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_T0;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_T0: if (Run) state_n = S_T1;
      S_T1: state_n = S_T2;
      S_T2: begin
        unique case (1'b1)
          (op == OP_LD),
          (op == OP_ST):  state_n = S_T3;
          (op == OP_HLT): state_n = S_HALT;
          default:        state_n = S_T0;
        endcase
      end
      S_T3:   state_n = S_T0;
      S_HALT: state_n = S_HALT;
      default: state_n = S_T0;
    endcase
  end

  always_comb begin
    bus.RF_OutASel  = 3'b000;
    bus.RF_OutBSel  = 3'b000;
    bus.RF_FunSel   = 2'b01;
    bus.RF_RSel     = 4'b0000;
    bus.RF_TSel     = 4'b0000;
    bus.ALU_FunSel  = 4'b0000;
    bus.ARF_OutCSel = 2'b00;
    bus.ARF_OutDSel = 2'b00;
    bus.ARF_FunSel  = 2'b01;
    bus.ARF_RegSel  = 4'b0000;
    bus.IR_LH       = 1'b0;
    bus.IR_Enable   = 1'b0;
    bus.IR_Funsel   = 2'b01;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = 2'b00;
    bus.MuxBSel     = 2'b00;
    bus.MuxCSel     = 1'b0;
    Halted          = 1'b0;
    Illegal         = 1'b0;
    Step            = state;
    if (Reset) begin
      // Clear every register on the reset cycle.
      bus.RF_RSel    = 4'b1111;
      bus.RF_TSel    = 4'b1111;
      bus.RF_FunSel  = 2'b00;
      bus.ARF_RegSel = 4'b1110;
      bus.ARF_FunSel = 2'b00;
      bus.IR_Enable  = 1'b1;
      bus.IR_Funsel  = 2'b00;
      Step           = 3'd0;
    end else begin
      unique case (state)
        S_T0, S_T1: begin
          if (Run || state == S_T1) begin
            bus.ARF_OutDSel = PC_SEL;
            bus.Mem_CS      = 1'b0;
            bus.IR_Enable   = 1'b1;
            bus.IR_LH       = (state == S_T1);
            bus.ARF_RegSel  = 4'b1000;
            bus.ARF_FunSel  = 2'b11;
          end
        end
        S_T2: begin
          unique case (1'b1)
            (op == OP_ALU): begin
              bus.RF_OutASel = {1'b1, dst};
              bus.RF_OutBSel = {1'b1, src};
              bus.ALU_FunSel = bus.IROut[7:4];
              bus.RF_RSel    = dst_oh;
            end
            (op == OP_LDI): begin
              bus.MuxASel = 2'b10;
              bus.RF_RSel = dst_oh;
            end
            (op == OP_LD), (op == OP_ST): begin
              bus.MuxBSel    = 2'b10;
              bus.ARF_RegSel = 4'b0100;
            end
            (op == OP_BRA): begin
              bus.MuxBSel    = 2'b10;
              bus.ARF_RegSel = 4'b1000;
            end
            (op == OP_BZ): begin
              if (bus.ALU_Flag[3]) begin
                bus.MuxBSel    = 2'b10;
                bus.ARF_RegSel = 4'b1000;
              end
            end
            (op == OP_HLT): ;
            default: Illegal = 1'b1;
          endcase
        end
        S_T3: begin
          bus.ARF_OutDSel = AR_SEL;
          bus.Mem_CS      = 1'b0;
          if (op == OP_ST) begin
            bus.RF_OutASel = {1'b1, src};
            bus.Mem_WR     = 1'b1;
          end else begin
            bus.MuxASel = 2'b01;
            bus.RF_RSel = dst_oh;
          end
        end
        S_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer against an instruction-level model.
// Ports: drives Clock/Reset/Run and bus IROut/ALU_Flag; checks all outputs.
module tb_control_sequencer;

  typedef struct packed {
    logic [2:0] rf_a;
    logic [2:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rf_r;
    logic [3:0] rf_t;
    logic [3:0] alu_fun;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [3:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
    logic       illegal;
    logic [2:0] step;
  } ctl_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b0;
  logic       Halted, Illegal;
  logic [2:0] Step;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Run     (Run),
    .bus     (bus.master),
    .Halted  (Halted),
    .Illegal (Illegal),
    .Step    (Step)
  );

  always #5 Clock = ~Clock;

  ctl_t obs;
  assign obs = '{
    rf_a: bus.RF_OutASel, rf_b: bus.RF_OutBSel,
    rf_fun: bus.RF_FunSel, rf_r: bus.RF_RSel,
    rf_t: bus.RF_TSel, alu_fun: bus.ALU_FunSel,
    arf_c: bus.ARF_OutCSel, arf_d: bus.ARF_OutDSel,
    arf_fun: bus.ARF_FunSel, arf_reg: bus.ARF_RegSel,
    ir_lh: bus.IR_LH, ir_en: bus.IR_Enable,
    ir_fun: bus.IR_Funsel, mem_wr: bus.Mem_WR,
    mem_cs: bus.Mem_CS, mux_a: bus.MuxASel,
    mux_b: bus.MuxBSel, mux_c: bus.MuxCSel,
    halted: Halted, illegal: Illegal, step: Step
  };

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model: where we are inside the current instruction.
  int m_k = 0;
  bit m_halt = 0;

  function automatic int op_len(input logic [15:0] ir);
    return (ir[15:12] == 4'h2 || ir[15:12] == 4'h3) ? 4 : 3;
  endfunction

  function automatic ctl_t model_vec(input bit rst, input bit hlt,
                                     input int k, input bit run,
                                     input logic [15:0] ir,
                                     input logic [3:0] fl);
    ctl_t v;
    logic [3:0] op, oh;
    logic [1:0] d, s;
    v = '0;
    v.rf_fun = 2'b01; v.arf_fun = 2'b01;
    v.ir_fun = 2'b01; v.mem_cs = 1'b1;
    op = ir[15:12]; d = ir[11:10]; s = ir[9:8];
    oh = 4'b1000 >> d;
    if (rst) begin
      v.rf_r = 4'hF; v.rf_t = 4'hF; v.rf_fun = 2'b00;
      v.arf_reg = 4'b1110; v.arf_fun = 2'b00;
      v.ir_en = 1'b1; v.ir_fun = 2'b00;
    end else if (hlt) begin
      v.halted = 1'b1; v.step = 3'd7;
    end else begin
      v.step = 3'(k);
      if ((k == 0 && run) || k == 1) begin
        v.arf_d = 2'b00; v.mem_cs = 1'b0; v.ir_en = 1'b1;
        v.ir_lh = (k == 1); v.arf_reg = 4'b1000;
        v.arf_fun = 2'b11;
      end else if (k == 2) begin
        case (op)
          4'h0: begin
            v.rf_a = {1'b1, d}; v.rf_b = {1'b1, s};
            v.alu_fun = ir[7:4]; v.rf_r = oh;
          end
          4'h1: begin v.mux_a = 2'b10; v.rf_r = oh; end
          4'h2, 4'h3: begin v.mux_b = 2'b10; v.arf_reg = 4'b0100; end
          4'h4: begin v.mux_b = 2'b10; v.arf_reg = 4'b1000; end
          4'h5: if (fl[3]) begin
            v.mux_b = 2'b10; v.arf_reg = 4'b1000;
          end
          4'h6: ;
          default: v.illegal = 1'b1;
        endcase
      end else if (k == 3) begin
        v.arf_d = 2'b01; v.mem_cs = 1'b0;
        if (op == 4'h3) begin
          v.rf_a = {1'b1, s}; v.mem_wr = 1'b1;
        end else begin
          v.mux_a = 2'b01; v.rf_r = oh;
        end
      end
    end
    return v;
  endfunction

  task automatic settle(input bit rst, input bit run);
    ctl_t e;
    Reset = rst;
    Run = run;
    @(negedge Clock);
    e = model_vec(rst, m_halt, m_k, run, bus.IROut, bus.ALU_Flag);
    chk("vec", 64'(obs), 64'(e));
  endtask

  task automatic adv();
    @(posedge Clock);
    #1;
    if (Reset) begin
      m_k = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (m_k == 0 && !Run) m_k = 0;
      else if (m_k == 2 && bus.IROut[15:12] == 4'h6) begin
        m_halt = 1; m_k = 0;
      end else if (m_k + 1 == op_len(bus.IROut)) m_k = 0;
      else m_k = m_k + 1;
    end
  endtask

  task automatic instr(input logic [15:0] ir, input logic [3:0] fl,
                       input int lat);
    int n;
    n = 0;
    bus.IROut = ir;
    bus.ALU_Flag = fl;
    do begin
      settle(0, 1);
      adv();
      n++;
    end while (m_k != 0 && !m_halt && n < 8);
    chk("latency", 64'(n), 64'(lat));
  endtask

  initial begin
    bus.IROut = 16'h0000;
    bus.ALU_Flag = 4'h0;
    @(posedge Clock); #1;

    settle(1, 0);
    chk("rst_rsel", 64'(bus.RF_RSel), 64'hF);
    chk("rst_regsel", 64'(bus.ARF_RegSel), 64'hE);
    chk("rst_cs", 64'(bus.Mem_CS), 64'h1);
    adv();
    settle(0, 0);
    chk("idle_step", 64'(Step), 64'h0);
    chk("idle_cs", 64'(bus.Mem_CS), 64'h1);
    adv();
    settle(0, 0);
    adv();

    instr(16'h142A, 4'h0, 3);
    instr(16'h0630, 4'h0, 3);
    instr(16'h2C80, 4'h0, 4);
    instr(16'h3580, 4'h0, 4);
    instr(16'h4020, 4'h0, 3);
    instr(16'h5010, 4'h8, 3);
    instr(16'h5010, 4'h0, 3);

    bus.IROut = 16'hF000;
    settle(0, 1); adv();
    settle(0, 1); adv();
    settle(0, 1);
    chk("illegal_t2", 64'(Illegal), 64'h1);
    adv();
    settle(0, 0);
    chk("illegal_pulse", 64'(Illegal), 64'h0);
    adv();

    instr(16'h6000, 4'h0, 3);
    for (int i = 0; i < 4; i++) begin
      settle(0, i[0]);
      chk("halt_step", 64'(Step), 64'h7);
      adv();
    end
    settle(1, 0); adv();
    settle(0, 0);
    chk("unhalt", 64'(Halted), 64'h0);
    adv();

    for (int c = 0; c < 3000; c++) begin
      bit rst, run;
      logic [15:0] ir;
      if (m_k == 0 && !m_halt) begin
        ir = 16'($urandom);
        if ($urandom_range(9) < 7) ir[15:12] = 4'($urandom_range(5));
        else if ($urandom_range(3) == 0) ir[15:12] = 4'h6;
        bus.IROut = ir;
      end
      bus.ALU_Flag = 4'($urandom);
      rst = ($urandom_range(39) == 0) ||
            (m_halt && $urandom_range(3) == 0);
      run = ($urandom_range(3) != 0);
      settle(rst, run);
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
